// File: rtl/seq_reduce_unit_pkg.sv
// Shared definitions for the Kolache ALU reduce/flag path.
// Op codes, FSM state encodings and accumulator helpers.
package seq_reduce_unit_pkg;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic acc_init(input logic [1:0] op);
        return (op == OP_AND);
    endfunction

    // NOR accumulates as OR; the inversion happens once at the end
    function automatic logic acc_fold(
        input logic       acc,
        input logic       part,
        input logic [1:0] op
    );
        logic r;
        unique case (1'b1)
            (op == OP_AND): r = acc & part;
            (op == OP_XOR): r = acc ^ part;
            default:        r = acc | part;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_reduce_unit_lane.sv
// Combinational single-lane reduction.
// NOR lanes reduce as OR; the top applies the final inversion.
module reduce_lane
    import seq_reduce_unit_pkg::*;
#(
    parameter int LANE = 8
) (
    input  logic [LANE-1:0] bits,
    input  logic [1:0]      op,
    output logic            part
);

    always_comb begin
        part = 1'b0;
        unique case (1'b1)
            (op == OP_AND): part = &bits;
            (op == OP_XOR): part = ^bits;
            default:        part = |bits;
        endcase
    end

endmodule

// File: rtl/seq_reduce_unit.sv
// Multi-cycle OR/AND/XOR/NOR reduction over {a,b}, LANE bits per clock,
// with valid/ready handshakes on both sides.
module seq_reduce_unit
    import seq_reduce_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y,
    output logic             busy
);

    localparam int VW = 2 * WIDTH;
    localparam int N  = VW / LANE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (LANE < 1 || (VW % LANE) != 0) begin : g_bad_lane
            $error("seq_reduce_unit: LANE must divide 2*WIDTH");
        end
    endgenerate

    logic [1:0]    state;
    logic [VW-1:0] sreg;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic          acc;
    logic          y_q;
    logic          part;
    logic          acc_nxt;

    reduce_lane #(.LANE(LANE)) u_lane (
        .bits (sreg[LANE-1:0]),
        .op   (op_q),
        .part (part)
    );

    assign acc_nxt   = acc_fold(acc, part, op_q);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign y         = y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            op_q  <= OP_OR;
            acc   <= 1'b0;
            y_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sreg  <= {a, b};
                        op_q  <= op;
                        cnt   <= '0;
                        acc   <= acc_init(op);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc  <= acc_nxt;
                    sreg <= sreg >> LANE;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                        y_q   <= (op_q == OP_NOR) ? ~acc_nxt : acc_nxt;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
